// File: rtl/immediate_pipe.sv
// RISC-V immediate extractor behind a 2-entry FIFO (output register + skid register).
// Decodes format and sign-extended immediate at accept time; emits in order.
module immediate_pipe #(
    parameter int XLEN     = 32,
    parameter bit RV64_OPS = 1'b0
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt
);

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_IMM_32   = 7'b0011011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_STORE_FP = 7'b0100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    localparam bit OP_IMM_32_EN = RV64_OPS && (XLEN == 64);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } count_t;

    count_t count;

    logic [2:0]      dec_fmt;
    logic [31:0]     dec_imm32;
    logic [XLEN-1:0] dec_imm;
    logic [31:0]     skid_inst;
    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_fmt;
    logic            accept;
    logic            emit;

    assign in_ready  = (count != FULL);
    assign out_valid = (count != EMPTY);
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    always_comb begin
        dec_fmt = FMT_NONE;
        case (in_inst[6:0])
            OP_LOAD, OP_LOAD_FP, OP_OP_IMM, OP_JALR: dec_fmt = FMT_I;
            OP_IMM_32:            if (OP_IMM_32_EN) dec_fmt = FMT_I;
            OP_STORE, OP_STORE_FP: dec_fmt = FMT_S;
            OP_BRANCH:            dec_fmt = FMT_B;
            OP_AUIPC, OP_LUI:     dec_fmt = FMT_U;
            OP_JAL:               dec_fmt = FMT_J;
            default:              dec_fmt = FMT_NONE;
        endcase
    end

    always_comb begin
        dec_imm32 = '0;
        case (dec_fmt)
            FMT_I: dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            FMT_S: dec_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            FMT_B: dec_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                in_inst[30:25], in_inst[11:8], 1'b0};
            FMT_U: dec_imm32 = {in_inst[31:12], 12'b0};
            FMT_J: dec_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                in_inst[20], in_inst[30:21], 1'b0};
            default: dec_imm32 = '0;
        endcase
    end

    // Every format's 32-bit immediate already carries inst[31] in bit 31, so widening is a plain sext.
    generate
        if (XLEN == 64) begin : g_sext64
            assign dec_imm = {{(XLEN-32){dec_imm32[31]}}, dec_imm32};
        end else begin : g_sext32
            assign dec_imm = dec_imm32;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count     <= EMPTY;
            out_inst  <= '0;
            out_imm   <= '0;
            out_fmt   <= FMT_NONE;
            skid_inst <= '0;
            skid_imm  <= '0;
            skid_fmt  <= FMT_NONE;
        end else begin
            case (count)
                EMPTY: if (accept) begin
                    out_inst <= in_inst;
                    out_imm  <= dec_imm;
                    out_fmt  <= dec_fmt;
                    count    <= ONE;
                end
                ONE: begin
                    // Simultaneous accept+emit bypasses the skid and refills the output directly.
                    if (accept && emit) begin
                        out_inst <= in_inst;
                        out_imm  <= dec_imm;
                        out_fmt  <= dec_fmt;
                    end else if (accept) begin
                        skid_inst <= in_inst;
                        skid_imm  <= dec_imm;
                        skid_fmt  <= dec_fmt;
                        count     <= FULL;
                    end else if (emit) begin
                        count <= EMPTY;
                    end
                end
                FULL: if (emit) begin
                    out_inst <= skid_inst;
                    out_imm  <= skid_imm;
                    out_fmt  <= skid_fmt;
                    count    <= ONE;
                end
                default: count <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_immediate_pipe.sv
// Self-checking bench for immediate_pipe: scoreboard on an XLEN=32 instance,
// directed checks on an XLEN=64 / RV64_OPS=1 instance.
module tb_immediate_pipe;

    logic        clock;
    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, out_inst, out_imm;
    logic [2:0]  out_fmt;

    logic        v_in_valid, v_in_ready, v_out_valid, v_out_ready;
    logic [31:0] v_in_inst, v_out_inst;
    logic [63:0] v_out_imm;
    logic [2:0]  v_out_fmt;

    int tests_run = 0;
    int fails     = 0;
    int emitted   = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [2:0]  fmt;
    } exp_t;
    exp_t q[$];

    immediate_pipe #(.XLEN(32), .RV64_OPS(1'b0)) dut32 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_imm(out_imm), .out_fmt(out_fmt)
    );

    immediate_pipe #(.XLEN(64), .RV64_OPS(1'b1)) dut64 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(v_in_valid), .in_ready(v_in_ready), .in_inst(v_in_inst),
        .out_valid(v_out_valid), .out_ready(v_out_ready),
        .out_inst(v_out_inst), .out_imm(v_out_imm), .out_fmt(v_out_fmt)
    );

    always #5 clock = ~clock;

    // Reference decode for the 32-bit instance (OP_IMM_32 is not I-type there).
    function automatic exp_t ref_dec(input logic [31:0] i);
        exp_t e;
        e.inst = i;
        e.fmt  = 3'd0;
        e.imm  = 32'd0;
        case (i[6:0])
            7'h03, 7'h07, 7'h13, 7'h67: begin
                e.fmt = 3'd1; e.imm = {{20{i[31]}}, i[31:20]};
            end
            7'h23, 7'h27: begin
                e.fmt = 3'd2; e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
            end
            7'h63: begin
                e.fmt = 3'd3; e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            7'h17, 7'h37: begin
                e.fmt = 3'd4; e.imm = {i[31:12], 12'b0};
            end
            7'h6F: begin
                e.fmt = 3'd5; e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [6:0] ops [12] = '{7'h03, 7'h07, 7'h13, 7'h1B, 7'h67, 7'h23,
                                 7'h27, 7'h63, 7'h17, 7'h37, 7'h6F, 7'h33};
        logic [31:0] r;
        r = $urandom;
        return {r[31:7], ops[$urandom_range(11, 0)]};
    endfunction

    // Scoreboard + hold-stability monitor; emitted entry is popped before the new one is pushed.
    logic        stall_prev = 1'b0;
    logic [66:0] held;
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset_n) begin
            if (stall_prev && out_valid) begin
                tests_run++;
                if ({out_inst, out_imm, out_fmt} !== held) begin
                    fails++;
                    $display("FAIL hold_stable: got %h, required %h", {out_inst, out_imm, out_fmt}, held);
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_inst, out_imm, out_fmt};
            if (out_valid && out_ready) begin
                tests_run++;
                emitted++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got inst %h, required no output", out_inst);
                end else begin
                    e = q.pop_front();
                    if ({out_inst, out_imm, out_fmt} !== {e.inst, e.imm, e.fmt}) begin
                        fails++;
                        $display("FAIL sb_entry: got inst %h imm %h fmt %0d, required inst %h imm %h fmt %0d",
                                 out_inst, out_imm, out_fmt, e.inst, e.imm, e.fmt);
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(ref_dec(in_inst));
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic test_reset();
        #2;
        tests_run++;
        if ({out_valid, out_inst, out_imm, out_fmt} !== 68'd0) begin
            fails++;
            $display("FAIL reset_outputs: got valid %b inst %h imm %h fmt %0d, required all 0",
                     out_valid, out_inst, out_imm, out_fmt);
        end
        @(posedge clock); @(posedge clock); #1 reset_n = 1'b1;
        @(negedge clock);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: got in_ready %b out_valid %b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        @(posedge clock); #1 in_valid = 1'b1; in_inst = 32'hFFF00093;
        @(posedge clock); #1 in_inst = 32'hFE112E23;
        tests_run++;
        if (out_valid !== 1'b1 || out_fmt !== 3'd1 || out_imm !== 32'hFFFFFFFF) begin
            fails++;
            $display("FAIL addi_latency: got valid %b fmt %0d imm %h, required 1 1 ffffffff",
                     out_valid, out_fmt, out_imm);
        end
        @(posedge clock); #1 in_inst = 32'h0000007F;
        tests_run++;
        if (out_fmt !== 3'd2 || out_imm !== 32'hFFFFFFFC) begin
            fails++;
            $display("FAIL sw_imm: got fmt %0d imm %h, required 2 fffffffc", out_fmt, out_imm);
        end
        @(posedge clock); #1 in_valid = 1'b0;
        tests_run++;
        if (out_fmt !== 3'd0 || out_imm !== 32'd0 || out_inst !== 32'h0000007F) begin
            fails++;
            $display("FAIL none_fmt: got fmt %0d imm %h inst %h, required 0 0 0000007f",
                     out_fmt, out_imm, out_inst);
        end
        @(posedge clock); #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_drain: got out_valid %b, required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a = 32'h00A00513, b = 32'h00B50463, c = 32'h0000106F;
        @(posedge clock); #1 out_ready = 1'b0; in_valid = 1'b1; in_inst = a;
        @(posedge clock); #1 in_inst = b;
        @(posedge clock); #1 in_inst = c;
        tests_run++;
        if (in_ready !== 1'b0 || out_inst !== a) begin
            fails++;
            $display("FAIL b2b_full: got in_ready %b out_inst %h, required 0 %h", in_ready, out_inst, a);
        end
        @(posedge clock); #1;
        tests_run++;
        if (in_ready !== 1'b0 || out_inst !== a) begin
            fails++;
            $display("FAIL b2b_hold_c: got in_ready %b out_inst %h, required 0 %h", in_ready, out_inst, a);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_inst !== b || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_skid_move: got valid %b inst %h in_ready %b, required 1 %h 1",
                     out_valid, out_inst, in_ready, b);
        end
        @(posedge clock); #1 in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_inst !== c) begin
            fails++;
            $display("FAIL b2b_c_out: got valid %b inst %h, required 1 %h", out_valid, out_inst, c);
        end
        @(posedge clock); #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain: got out_valid %b, required 0", out_valid);
        end
    endtask

    task automatic test_stream();
        int start = emitted;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock); #1 in_valid = 1'b1; in_inst = rnd_inst();
            @(negedge clock);
            tests_run++;
            if (in_ready !== 1'b1 || (k > 0 && out_valid !== 1'b1)) begin
                fails++;
                $display("FAIL stream_cycle%0d: got in_ready %b out_valid %b, required 1 1", k, in_ready, out_valid);
            end
        end
        @(posedge clock); #1 in_valid = 1'b0;
        @(posedge clock); #1;
        tests_run++;
        if (emitted - start !== 8 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stream_count: got %0d emitted valid %b, required 8 0", emitted - start, out_valid);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            @(posedge clock); #1;
            in_valid  = 1'($urandom_range(1, 0));
            in_inst   = rnd_inst();
            out_ready = ($urandom_range(3, 0) != 0);
        end
        @(posedge clock); #1 in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        tests_run++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL random_drain: got %0d pending valid %b, required 0 0", q.size(), out_valid);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clock); #1 out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00100093;
        @(posedge clock); #1 in_inst = 32'h00200113;
        @(posedge clock); #1 in_valid = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        q.delete();
        tests_run++;
        if (out_valid !== 1'b0 || out_inst !== 32'd0 || out_imm !== 32'd0 || out_fmt !== 3'd0) begin
            fails++;
            $display("FAIL reset_async: got valid %b inst %h imm %h fmt %0d, required 0 0 0 0",
                     out_valid, out_inst, out_imm, out_fmt);
        end
        @(posedge clock); #1 reset_n = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_release: got in_ready %b out_valid %b, required 1 0", in_ready, out_valid);
        end
        repeat (3) @(negedge clock);
        tests_run++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_discard: got out_valid %b, required 0", out_valid);
        end
        @(posedge clock); #1 in_valid = 1'b1; in_inst = 32'h80000063;
        @(posedge clock); #1 in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_fmt !== 3'd3 || out_imm !== 32'hFFFFF000) begin
            fails++;
            $display("FAIL reset_mid_new: got valid %b fmt %0d imm %h, required 1 3 fffff000",
                     out_valid, out_fmt, out_imm);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_rv64();
        logic [31:0] ins  [7] = '{32'h800002B7, 32'hFFF0809B, 32'h7FF0809B, 32'h0000006F,
                                  32'h8000006F, 32'h80000063, 32'h00000033};
        logic [2:0]  fmts [7] = '{3'd4, 3'd1, 3'd1, 3'd5, 3'd5, 3'd3, 3'd0};
        logic [63:0] imms [7] = '{64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFF, 64'h00000000000007FF,
                                  64'h0, 64'hFFFFFFFFFFF00000, 64'hFFFFFFFFFFFFF000, 64'h0};
        v_out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clock); #1 v_in_valid = 1'b1; v_in_inst = ins[k];
            @(posedge clock); #1 v_in_valid = 1'b0;
            tests_run++;
            if (v_out_valid !== 1'b1 || v_out_fmt !== fmts[k] || v_out_imm !== imms[k] || v_out_inst !== ins[k]) begin
                fails++;
                $display("FAIL rv64_%0d: got valid %b fmt %0d imm %h, required 1 %0d %h",
                         k, v_out_valid, v_out_fmt, v_out_imm, fmts[k], imms[k]);
            end
        end
    endtask

    initial begin
        clock = 1'b0; reset_n = 1'b0;
        in_valid = 1'b0; in_inst = '0; out_ready = 1'b0;
        v_in_valid = 1'b0; v_in_inst = '0; v_out_ready = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_stream();
        test_random();
        test_rv64();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
